// File: rtl/seg_pkg.sv
// Shared widths and value types for the seven-segment scan controller.
package seg_pkg;

   localparam int SEG_DIGITS = 8;
   localparam int SEG_SEL_W  = 3;
   localparam int SEG_NIB_W  = 4;

   typedef logic [SEG_DIGITS*SEG_NIB_W-1:0] seg_value_t;
   typedef logic [SEG_DIGITS-1:0]           seg_mask_t;

endpackage

// File: rtl/seg_tick_div.sv
// Refresh divider: asserts tick for one cycle every REFRESH_DIV clocks.
module seg_tick_div #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int                DIV_W    = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   assign tick = (div_cnt == DIV_LAST);

   // Count 0..REFRESH_DIV-1 and wrap exactly at the last value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller. New values are staged in a
// one-deep pending register and promoted to the displayed value only when
// the scan wraps from digit 7 to digit 0, so no frame mixes old and new data.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  seg_value_t            data_in,
   input  seg_mask_t             blank_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [SEG_NIB_W-1:0]  num,
   output logic [SEG_SEL_W-1:0]  sel,
   output logic                  blank,
   output logic                  frame_done
);

   localparam logic [SEG_SEL_W-1:0] SEL_LAST = SEG_SEL_W'(SEG_DIGITS - 1);

   logic       tick;
   logic       wrap;
   seg_value_t active_data;
   seg_mask_t  active_blank;
   seg_value_t pending_data;
   seg_mask_t  pending_blank;
   logic       pending_flag;

   seg_tick_div #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_tick_div (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // The frame boundary is the tick that moves the scan off the last digit.
   assign wrap       = tick & (sel == SEL_LAST);
   assign data_ready = ~pending_flag;

   // Advance the digit index on each tick; flag the first cycle of a new frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel        <= '0;
         frame_done <= 1'b0;
      end else begin
         if (tick) begin
            sel <= sel + 1'b1;
         end
         frame_done <= wrap;
      end
   end

   // Stage accepted data; promote it to the displayed value at the frame boundary.
   // Accept and promote never coincide because ready is low while pending is full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_data   <= '0;
         active_blank  <= '1;
         pending_data  <= '0;
         pending_blank <= '1;
         pending_flag  <= 1'b0;
      end else begin
         if (wrap && pending_flag) begin
            active_data   <= pending_data;
            active_blank  <= pending_blank;
            pending_flag  <= 1'b0;
         end
         if (data_valid && !pending_flag) begin
            pending_data  <= data_in;
            pending_blank <= blank_in;
            pending_flag  <= 1'b1;
         end
      end
   end

   // Select the nibble and blank bit of the digit currently being driven.
   always_comb begin
      num   = active_data[SEG_NIB_W*int'(sel) +: SEG_NIB_W];
      blank = active_blank[sel];
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a short refresh divider.
module tb_seg_scan_ctrl;

   localparam int RD    = 4;
   localparam int FRAME = 8 * RD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_in = '0;
   logic [7:0]  blank_in = '0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [3:0]  num;
   logic [2:0]  sel;
   logic        blank;
   logic        frame_done;

   seg_scan_ctrl #(.REFRESH_DIV(RD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .blank_in   (blank_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .num        (num),
      .sel        (sel),
      .blank      (blank),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: display position is derived from the number of clock
   // edges since reset; staged data is a single-entry slot promoted when the
   // edge count crosses a multiple of one frame.
   bit          model_on = 0;
   int unsigned m_n = 0;
   logic [31:0] m_act = '0, m_pd = '0;
   logic [7:0]  m_ab = 8'hFF, m_pb = 8'hFF;
   bit          m_pf = 0, m_fd = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_n = 0; m_act = '0; m_ab = 8'hFF; m_pf = 0; m_fd = 0; model_on = 1;
      end else begin : mdl
         bit wrap_e, acc;
         wrap_e = (m_n % FRAME) == FRAME - 1;
         acc    = data_valid && !m_pf;
         if (wrap_e && m_pf) begin m_act = m_pd; m_ab = m_pb; m_pf = 0; end
         if (acc) begin m_pd = data_in; m_pb = blank_in; m_pf = 1; end
         m_fd = wrap_e;
         m_n++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare every output with the model.
   task automatic step();
      int ms;
      @(negedge clk);
      if (model_on) begin
         ms = int'((m_n / RD) % 8);
         chk("m_sel",   32'(sel),        32'(ms));
         chk("m_num",   32'(num),        (m_act >> (4 * ms)) & 32'hF);
         chk("m_blank", 32'(blank),      32'(m_ab[ms]));
         chk("m_ready", 32'(data_ready), 32'(!m_pf));
         chk("m_fdone", 32'(frame_done), 32'(m_fd));
      end
   endtask

   task automatic cyc(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic wait_frame();
      bit got = 0;
      for (int i = 0; i < 3 * FRAME && !got; i++) begin
         step();
         if (frame_done === 1'b1) got = 1;
      end
      chk("frame_wait", 32'(got), 32'd1);
   endtask

   task automatic send(input logic [31:0] d, input logic [7:0] b);
      bit taken = 0;
      data_in = d; blank_in = b; data_valid = 1'b1;
      for (int i = 0; i < 3 * FRAME && !taken; i++) begin
         taken = (data_ready === 1'b1);
         step();
      end
      data_valid = 1'b0;
      chk("send_taken", 32'(taken), 32'd1);
   endtask

   // Expected display per value: nibs/blanks are listed in scan order, sel 0 first (MSB).
   typedef struct {
      logic [31:0] data;
      logic [7:0]  bmask;
      logic [31:0] nibs;
      logic [7:0]  blanks;
   } vec_t;

   vec_t vecs[3];
   int   seen;

   initial begin
      vecs[0] = '{data: 32'h89ABCDEF, bmask: 8'h00, nibs: 32'hFEDCBA98, blanks: 8'b0000_0000};
      vecs[1] = '{data: 32'h00000042, bmask: 8'hFC, nibs: 32'h24000000, blanks: 8'b0011_1111};
      vecs[2] = '{data: 32'h12345678, bmask: 8'h0F, nibs: 32'h87654321, blanks: 8'b1111_0000};

      // Reset held for three cycles.
      @(negedge clk);
      rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      chk("rst_sel",   32'(sel), 0);
      chk("rst_num",   32'(num), 0);
      chk("rst_blank", 32'(blank), 1);
      chk("rst_ready", 32'(data_ready), 1);
      chk("rst_fdone", 32'(frame_done), 0);
      cyc(3);
      chk("sel_hold", 32'(sel), 0);
      cyc(1);
      chk("sel_step", 32'(sel), 1);

      // Table-driven apply of whole values, checked digit by digit.
      foreach (vecs[v]) begin
         send(vecs[v].data, vecs[v].bmask);
         chk("ready_low_pending", 32'(data_ready), 0);
         wait_frame();
         for (int d = 0; d < 8; d++) begin
            chk("tbl_sel",   32'(sel), 32'(d));
            chk("tbl_num",   32'(num), 32'(vecs[v].nibs[31-4*d -: 4]));
            chk("tbl_blank", 32'(blank), 32'(vecs[v].blanks[7-d]));
            if (d == 0) chk("tbl_ready", 32'(data_ready), 1);
            cyc(RD);
         end
         chk("tbl_frame_pulse", 32'(frame_done), 1);
      end

      // Back-pressure: a second value offered while pending is full waits.
      send(32'hCAFE0123, 8'h00);
      data_in = 32'h11111111; blank_in = 8'h00; data_valid = 1'b1;
      cyc(3);
      chk("bp_ready", 32'(data_ready), 0);
      send(32'h11111111, 8'h00);
      chk("bp_old_digit0", 32'(num), 3);
      wait_frame();
      chk("bp_new_digit0", 32'(num), 1);

      // Accept on the exact wrap edge lands in the following frame.
      cyc(FRAME - 1);
      data_in = 32'h5A5A5A5A; blank_in = 8'h00; data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      chk("bnd_fdone", 32'(frame_done), 1);
      chk("bnd_num_old", 32'(num), 1);
      chk("bnd_ready", 32'(data_ready), 0);
      wait_frame();
      chk("bnd_num_new", 32'(num), 32'hA);

      // Reset mid-frame with a pending value discards it.
      send(32'h77777777, 8'h00);
      for (int i = 0; i < 2 * FRAME && sel != 3'd5; i++) step();
      chk("mrst_at5", 32'(sel), 5);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mrst_sel", 32'(sel), 0);
      chk("mrst_blank", 32'(blank), 1);
      chk("mrst_ready", 32'(data_ready), 1);
      chk("mrst_num", 32'(num), 0);
      seen = 0;
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         step();
         if (blank !== 1'b1) seen++;
      end
      chk("mrst_discard", 32'(seen), 0);

      // Randomized traffic with occasional resets, checked against the model.
      for (int i = 0; i < 3000; i++) begin
         data_valid = ($urandom % 4) == 0;
         data_in    = $urandom;
         blank_in   = 8'($urandom);
         rst_n      = ($urandom % 500) != 0;
         step();
      end
      rst_n = 1'b1;
      data_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
